add_sub_seq: RTL

ADD_SUB_SEQ -- requirements
Module: add_sub_seq

---
 rtl/add_sub_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/add_sub_seq.sv
// -----------------------------------------------------------------------------
// add_sub_seq
//   Sequential adder/subtractor that processes CHUNK bits per clock. Operands
//   are captured on the in_valid/in_ready handshake. The result is built one
//   slice per cycle and then presented on out_valid/out_ready. Subtraction is
//   done as A + ~B + 1, so cout=1 in subtract mode means "no borrow".
//
// Parameters
//   WIDTH  operand/result width in bits
//   CHUNK  bits added per cycle; WIDTH must be a multiple of CHUNK
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands valid          in_ready   idle, will accept
//   A, B       operands                cin        carry-in (add mode only)
//   sub        0 = add, 1 = subtract
//   S          registered result
//   cout       final carry-out         ovf        signed overflow
//   zero       S == 0                  neg        S[WIDTH-1]
//   out_valid  result valid            out_ready  consumer takes result
// -----------------------------------------------------------------------------
module add_sub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;        // already inverted when subtracting
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] a_slice, b_slice;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;
  int               base;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    carry_d     = carry_q;
    k_d         = k_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    base       = int'(k_q) * CHUNK;
    a_slice    = a_q[base +: CHUNK];
    b_slice    = b_q[base +: CHUNK];
    chunk_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (k_q == KW'(N - 1));

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = A;
          b_d        = B ^ {WIDTH{sub}};
          carry_d    = sub | cin;   // the +1 of two's complement when subtracting
          k_d        = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end

      RUN: begin
        s_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d            = chunk_sum[CHUNK];
        if (last_chunk) begin
          k_d         = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          cout_d      = chunk_sum[CHUNK];
          // Carry into the MSB is recovered from the MSB's sum bit:
          // s = a ^ b ^ c_in  =>  c_in = a ^ b ^ s.
          ovf_d       = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_d[WIDTH-1]) ^ chunk_sum[CHUNK];
          zero_d      = (s_d == '0);
          neg_d       = s_d[WIDTH-1];
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control, result and flags: reset wins over any handshake in the same cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      carry_q     <= carry_d;
      k_q         <= k_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: operand registers carry no reset; they are always loaded on accept
  // before being read, so resetting them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule
